// File: rtl/opb_register_simulink2ppc_snap_pkg.sv
// Shared definitions for the fabric-to-PPC snapshot register block:
// register offsets, CTRL bit positions, slave FSM states and counter width.
package opb_s2p_pkg;

  // Byte offsets of the registers inside the 256-byte window
  localparam logic [7:0] OFF_DATA   = 8'h00;
  localparam logic [7:0] OFF_STATUS = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;

  // CTRL register bit positions (register numbering, bit 0 = LSB)
  localparam int CTRL_FREEZE    = 0;
  localparam int CTRL_CLR_COUNT = 1;

  // Capture counter width
  localparam int COUNT_W = 16;

  // OPB slave sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  // STATUS layout: count in [31:16], fresh in bit 0, everything else zero
  function automatic logic [31:0] status_word(input logic [COUNT_W-1:0] count,
                                              input logic fresh);
    return {count, 15'b0, fresh};
  endfunction

endpackage

// File: rtl/opb_register_simulink2ppc_snap_if.sv
// OPB slave-side signal bundle. Vectors keep the OPB big-endian numbering,
// so index 0 is the most significant bit of address and data.
interface opb_register_simulink2ppc_snap_if;
  logic [0:31] OPB_ABus;
  logic [0:3]  OPB_BE;
  logic [0:31] OPB_DBus;
  logic        OPB_RNW;
  logic        OPB_select;
  logic        OPB_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck;
  logic        Sl_errAck;
  logic        Sl_retry;
  logic        Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_register_simulink2ppc_snap_slave_fsm.sv
// OPB slave sequencer: decodes the address window, produces a single
// registered acknowledge per select assertion and the one-cycle read/write
// strobes plus word index used by the register file.
module opb_slave_fsm
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_addr,
  input  logic        i_select,
  input  logic        i_rnw,
  output logic        o_rd_strobe,
  output logic        o_wr_strobe,
  output logic [5:0]  o_word_idx,
  output logic        o_xfer_ack
);

  state_t r_state;
  logic   r_ack;
  logic   w_hit;
  logic   w_start;

  assign w_hit   = i_select && (i_addr >= C_BASEADDR) && (i_addr <= C_HIGHADDR);
  // A transfer starts only from IDLE, which is what limits acks to one per select
  assign w_start = (r_state == IDLE) && w_hit;

  assign o_rd_strobe = w_start && i_rnw;
  assign o_wr_strobe = w_start && !i_rnw;
  assign o_word_idx  = i_addr[7:2];
  assign o_xfer_ack  = r_ack;

  // IDLE -> ACK on hit, ACK -> WAIT, WAIT -> IDLE once select drops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
          end
        end
        ACK:     r_state <= WAIT;
        WAIT:    if (!i_select) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/opb_register_simulink2ppc_snap.sv
// Fabric-to-PPC snapshot registers on OPB: captures a user word on each
// strobe, tracks freshness and a wrapping capture count, and exposes
// DATA / STATUS / CTRL to OPB reads.
module opb_register_simulink2ppc_snap
  import opb_s2p_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'hFFFFFFFF,
  parameter logic [31:0] C_HIGHADDR   = 32'h00000000,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                                OPB_Clk,
  input  logic                                OPB_Rst_n,
  opb_register_simulink2ppc_snap_if.slave     bus,
  input  logic [31:0]                         user_data_in,
  input  logic                                user_data_valid,
  output logic                                user_frozen
);

  logic [C_OPB_AWIDTH-1:0] w_addr;
  logic [C_OPB_DWIDTH-1:0] w_wdata;
  logic                    w_rd_strobe;
  logic                    w_wr_strobe;
  logic [5:0]              w_word_idx;
  logic [7:0]              w_offset;
  logic                    w_capture;
  logic                    w_ctrl_wr;
  logic                    w_clr_count;
  logic                    w_data_rd;
  logic [31:0]             w_rd_word;

  logic [31:0]             r_data;
  logic                    r_fresh;
  logic [COUNT_W-1:0]      r_count;
  logic                    r_freeze;
  logic [31:0]             r_dbus;

  // Packed assignment reverses the OPB [0:31] numbering into [31:0]
  assign w_addr  = bus.OPB_ABus;
  assign w_wdata = bus.OPB_DBus;

  opb_slave_fsm #(
    .C_BASEADDR (C_BASEADDR),
    .C_HIGHADDR (C_HIGHADDR)
  ) u_fsm (
    .clk         (OPB_Clk),
    .rst_n       (OPB_Rst_n),
    .i_addr      (w_addr[31:0]),
    .i_select    (bus.OPB_select),
    .i_rnw       (bus.OPB_RNW),
    .o_rd_strobe (w_rd_strobe),
    .o_wr_strobe (w_wr_strobe),
    .o_word_idx  (w_word_idx),
    .o_xfer_ack  (bus.Sl_xferAck)
  );

  assign w_offset    = {w_word_idx, 2'b00};
  assign w_capture   = user_data_valid && !r_freeze;
  // Only the lane holding register bits [7:0] (OPB_BE[3]) can modify CTRL
  assign w_ctrl_wr   = w_wr_strobe && (w_offset == OFF_CTRL) && bus.OPB_BE[3];
  assign w_clr_count = w_ctrl_wr && w_wdata[CTRL_CLR_COUNT];
  assign w_data_rd   = w_rd_strobe && (w_offset == OFF_DATA);

  // Read mux from current register contents; unmapped offsets read zero
  always_comb begin
    w_rd_word = 32'h0;
    unique case (w_offset)
      OFF_DATA:   w_rd_word = r_data;
      OFF_STATUS: w_rd_word = status_word(r_count, r_fresh);
      OFF_CTRL:   w_rd_word = {31'b0, r_freeze};
      default:    w_rd_word = 32'h0;
    endcase
  end

  // Latch the user word on an unfrozen strobe
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_data <= 32'h0;
    else if (w_capture) r_data <= user_data_in;
  end

  // Fresh: a capture wins over a simultaneous DATA read
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_fresh <= 1'b0;
    else if (w_capture) r_fresh <= 1'b1;
    else if (w_data_rd) r_fresh <= 1'b0;
  end

  // Capture counter; a clear coinciding with a capture leaves one count
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_count <= '0;
    else if (w_clr_count) r_count <= w_capture ? COUNT_W'(1) : '0;
    else if (w_capture) r_count <= r_count + COUNT_W'(1);
  end

  // Freeze bit; clear_count is a pulse and is never stored
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_freeze <= 1'b0;
    else if (w_ctrl_wr) r_freeze <= w_wdata[CTRL_FREEZE];
  end

  // Read data is loaded only alongside the ack, so the bus is zero otherwise
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_dbus <= 32'h0;
    else r_dbus <= w_rd_strobe ? w_rd_word : 32'h0;
  end

  assign bus.Sl_DBus    = r_dbus;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;
  assign user_frozen    = r_freeze;

endmodule

// File: tb/tb_opb_register_simulink2ppc_snap.sv
// Directed bench for the snapshot register block: drives OPB transfers
// and capture strobes, checks read data, ack counts and side effects.
module tb_opb_register_simulink2ppc_snap;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam logic [31:0] HIGH   = 32'h8000_00FF;
  localparam logic [31:0] A_DATA = BASE + 32'h0;
  localparam logic [31:0] A_STAT = BASE + 32'h4;
  localparam logic [31:0] A_CTRL = BASE + 32'h8;

  logic        clk;
  logic        rst_n;
  logic [31:0] user_data_in;
  logic        user_data_valid;
  logic        user_frozen;

  int checks = 0;
  int errors = 0;

  opb_register_simulink2ppc_snap_if bus();

  opb_register_simulink2ppc_snap #(
    .C_BASEADDR (BASE),
    .C_HIGHADDR (HIGH)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .bus             (bus),
    .user_data_in    (user_data_in),
    .user_data_valid (user_data_valid),
    .user_frozen     (user_frozen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One OPB transfer; optional capture strobe in the select-sampling cycle.
  // Select is held through the ack cycle and dropped the cycle after.
  task automatic xfer(input logic [31:0] addr, input logic rnw, input logic [0:3] be,
                      input logic [31:0] wdata, input logic cap_v, input logic [31:0] cap_d,
                      output logic [31:0] rdata, output int acks, output int lat);
    acks  = 0;
    lat   = 0;
    rdata = 32'h0;
    @(posedge clk); #1;
    bus.OPB_ABus    = addr;
    bus.OPB_RNW     = rnw;
    bus.OPB_BE      = be;
    bus.OPB_DBus    = wdata;
    bus.OPB_select  = 1'b1;
    user_data_valid = cap_v;
    user_data_in    = cap_d;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      user_data_valid = 1'b0;
      if (bus.Sl_xferAck) begin
        acks++;
        if (lat == 0) begin
          lat   = c;
          rdata = bus.Sl_DBus;
        end
      end
      if (lat != 0 && c > lat) bus.OPB_select = 1'b0;
    end
    bus.OPB_select = 1'b0;
    $display("xfer addr=%h rnw=%0d be=%b wdata=%h rdata=%h acks=%0d lat=%0d",
             addr, rnw, be, wdata, rdata, acks, lat);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    int a, l;
    xfer(addr, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, d, a, l);
    check({tag, " data"}, d, exp);
    check({tag, " acks"}, 32'(a), 32'd1);
    check({tag, " lat"}, 32'(l), 32'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [0:3] be,
                    input logic [31:0] wdata);
    logic [31:0] d;
    int a, l;
    xfer(addr, 1'b0, be, wdata, 1'b0, 32'h0, d, a, l);
    check({tag, " acks"}, 32'(a), 32'd1);
  endtask

  task automatic capture(input logic [31:0] d);
    @(posedge clk); #1;
    user_data_valid = 1'b1;
    user_data_in    = d;
    @(posedge clk); #1;
    user_data_valid = 1'b0;
    $display("capture data=%h", d);
  endtask

  initial begin
    logic [31:0] d;
    int a, l;
    rst_n           = 1'b0;
    user_data_in    = 32'h0;
    user_data_valid = 1'b0;
    bus.OPB_ABus    = 32'h0;
    bus.OPB_BE      = 4'b0000;
    bus.OPB_DBus    = 32'h0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_select  = 1'b0;
    bus.OPB_seqAddr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ack", {31'b0, bus.Sl_xferAck}, 32'h0);
    check("reset dbus", bus.Sl_DBus, 32'h0);
    check("reset frozen", {31'b0, user_frozen}, 32'h0);
    check("tied errack", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'h0);
    rst_n = 1'b1;

    // Reset values through the bus
    rd("rst DATA", A_DATA, 32'h0);
    rd("rst STATUS", A_STAT, 32'h0);
    rd("rst CTRL", A_CTRL, 32'h0);

    // Single capture, fresh set then cleared by DATA read
    capture(32'hDEADBEEF);
    rd("cap STATUS", A_STAT, 32'h0001_0001);
    rd("cap DATA", A_DATA, 32'hDEADBEEF);
    rd("cap STATUS2", A_STAT, 32'h0001_0000);

    // Freeze drops strobes
    wr("freeze wr", A_CTRL, 4'b0001, 32'h1);
    check("frozen out", {31'b0, user_frozen}, 32'h1);
    capture(32'h12345678);
    rd("frz DATA", A_DATA, 32'hDEADBEEF);
    rd("frz STATUS", A_STAT, 32'h0001_0000);
    rd("frz CTRL", A_CTRL, 32'h1);

    // Unfreeze and clear count, then wrap the counter
    wr("unfreeze clr", A_CTRL, 4'b0001, 32'h2);
    check("unfrozen out", {31'b0, user_frozen}, 32'h0);
    rd("clr STATUS", A_STAT, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 65536; i++) begin
      user_data_valid = 1'b1;
      user_data_in    = i;
      @(posedge clk); #1;
    end
    user_data_valid = 1'b0;
    $display("capture burst of 65536 words");
    rd("wrap STATUS", A_STAT, 32'h0000_0001);

    // clear_count together with a capture leaves count 1
    xfer(A_CTRL, 1'b0, 4'b0001, 32'h2, 1'b1, 32'h1111_1111, d, a, l);
    check("clr+cap acks", 32'(a), 32'd1);
    rd("clr+cap CTRL", A_CTRL, 32'h0);
    rd("clr+cap STATUS", A_STAT, 32'h0001_0001);

    // DATA read together with a capture returns the old word, fresh stays set
    xfer(A_DATA, 1'b1, 4'b1111, 32'h0, 1'b1, 32'hA5A5A5A5, d, a, l);
    check("rd+cap data", d, 32'h1111_1111);
    check("rd+cap acks", 32'(a), 32'd1);
    rd("rd+cap STATUS", A_STAT, 32'h0002_0001);
    rd("new DATA", A_DATA, 32'hA5A5A5A5);
    rd("new STATUS", A_STAT, 32'h0002_0000);

    // Select held for four cycles gives a single ack
    a = 0;
    @(posedge clk); #1;
    bus.OPB_ABus   = A_STAT;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_select = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (bus.Sl_xferAck) a++;
    end
    bus.OPB_select = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (bus.Sl_xferAck) a++;
    end
    $display("held select acks=%0d", a);
    check("held sel acks", 32'(a), 32'd1);

    // Outside the window: no ack
    xfer(BASE + 32'h100, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, d, a, l);
    check("above win acks", 32'(a), 32'd0);
    xfer(BASE - 32'h4, 1'b1, 4'b1111, 32'h0, 1'b0, 32'h0, d, a, l);
    check("below win acks", 32'(a), 32'd0);
    rd("unmapped", BASE + 32'h40, 32'h0);

    // Reset during the ack cycle clears outputs immediately
    wr("freeze2 wr", A_CTRL, 4'b0001, 32'h1);
    @(posedge clk); #1;
    bus.OPB_ABus   = A_DATA;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_select = 1'b1;
    @(posedge clk); #1;
    check("pre-rst ack", {31'b0, bus.Sl_xferAck}, 32'h1);
    check("pre-rst dbus", bus.Sl_DBus, 32'hA5A5A5A5);
    rst_n = 1'b0;
    #1;
    check("async rst ack", {31'b0, bus.Sl_xferAck}, 32'h0);
    check("async rst dbus", bus.Sl_DBus, 32'h0);
    check("async rst frozen", {31'b0, user_frozen}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post-rst ack", {31'b0, bus.Sl_xferAck}, 32'h1);
    check("post-rst dbus", bus.Sl_DBus, 32'h0);
    $display("reset mid-transfer sequence done");
    bus.OPB_select = 1'b0;
    repeat (2) @(posedge clk);

    // CTRL write without lane 3 is ignored
    wr("be1110 wr", A_CTRL, 4'b1110, 32'h1);
    check("be1110 frozen", {31'b0, user_frozen}, 32'h0);
    rd("be1110 CTRL", A_CTRL, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
